// File: rtl/arb8_pkg.sv
// Package: arb8_pkg
// Shared definitions for the 8-way round-robin arbiter.
//   NUM_REQ / ID_W  : requester count and grant ID width
//   arb_state_e     : arbiter FSM states (IDLE, BUSY)
//   id_to_onehot    : ID -> one-hot grant vector (ID 0 -> 8'b1000_0000)
//   onehot_to_id    : one-hot grant vector -> ID (MSB-first numbering)
package arb8_pkg;

    localparam int NUM_REQ = 8;
    localparam int ID_W    = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // IDs count from the MSB: req[7] is ID 0, req[0] is ID 7.
    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        return 8'h80 >> id;
    endfunction

    function automatic logic [ID_W-1:0] onehot_to_id(input logic [NUM_REQ-1:0] vec);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vec[i]) begin
                id = id | ID_W'(NUM_REQ - 1 - i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Module: rr_pick8
// Combinational round-robin winner selection.
//   req[7:0]    : level requests (bit 7 is ID 0)
//   ptr[2:0]    : ID with highest priority this round
//   mask[7:0]   : requests excluded from arbitration (same bit order as req)
//   found       : at least one eligible request
//   win_id[2:0] : first eligible ID scanning upward from ptr, modulo 8
module rr_pick8
    import arb8_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic               found,
    output logic [ID_W-1:0]    win_id
);

    logic [NUM_REQ-1:0]   by_id;   // by_id[i] = eligible request from ID i
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;     // rot[k] = by_id[(ptr + k) mod 8]
    logic [ID_W-1:0]      offset;

    // Reorder into ID order so the scan runs in the same direction as the IDs.
    always_comb begin
        by_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            by_id[i] = req[NUM_REQ-1-i] & ~mask[NUM_REQ-1-i];
        end
    end

    // Rotate by the pointer using a doubled vector, so the scan starts at ptr.
    assign dbl = {by_id, by_id};
    assign rot = NUM_REQ'(dbl >> ptr);

    // Lowest set bit of the rotated vector wins; descending loop leaves the
    // lowest index as the final assignment.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found  = 1'b1;
                offset = ID_W'(k);
            end
        end
    end

    // Undo the rotation; 3-bit add wraps modulo 8.
    assign win_id = ptr + offset;

endmodule

// File: rtl/rr_arbiter8_enc.sv
// Module: rr_arbiter8_enc
// Round-robin arbiter sharing one resource among 8 requesters, with a
// registered one-hot grant and a 3-bit binary grant ID (req[7] -> ID 0).
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined   : a grant is forcibly revoked after TIMEOUT_CYCLES BUSY cycles;
//               the revoked ID is blocked until its req is seen low; the
//               timeout port exists.
//   Undefined : a grant is held for as long as the owner requests.
//
// Parameters
//   TIMEOUT_CYCLES : hold limit with ARB_TIMEOUT_EN, legal 2..255
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous reset, active-high
//   req[7:0]  : level requests, held high by the owner for the whole use
//   gnt[7:0]  : one-hot grant, zero when idle
//   gnt_id    : binary owner ID, zero when idle
//   gnt_valid : grant active (|gnt)
//   timeout   : one-cycle pulse on forced revoke (ARB_TIMEOUT_EN only)
//   state_dbg : current FSM state, for observation
//
// Handshake: req is a level; the owner keeps its bit high while it uses the
// resource and drops it to release. A release ends the grant at the next edge,
// followed by exactly one IDLE cycle in which the next winner is chosen.
module rr_arbiter8_enc
    import arb8_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
`ifdef ARB_TIMEOUT_EN
    output logic               timeout,
`endif
    output arb_state_e         state_dbg
);

    arb_state_e         state_q;
    arb_state_e         state_d;
    logic [NUM_REQ-1:0] gnt_q;
    logic [ID_W-1:0]    gnt_id_q;
    logic [ID_W-1:0]    ptr_q;
    logic [NUM_REQ-1:0] pick_mask;
    logic               found;
    logic [ID_W-1:0]    win_id;
    logic               owner_req;
    logic               revoke;
    logic               release_now;

    // The owner is still requesting if its grant bit meets its req bit.
    assign owner_req   = |(req & gnt_q);
    assign release_now = (state_q == BUSY) && (!owner_req || revoke);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0]         hold_cnt;
    logic [NUM_REQ-1:0] mask_q;
    logic               timeout_q;

    assign revoke    = (state_q == BUSY) && owner_req && (hold_cnt == HOLD_LAST);
    assign pick_mask = mask_q;

    // hold_cnt sits at 0 in IDLE so it is already cleared on entry to BUSY.
    // A mask bit is set by a revoke and cleared once its req is sampled low.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt  <= '0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= revoke;
            mask_q    <= (mask_q & req) | (revoke ? gnt_q : '0);
            if (state_q == IDLE) begin
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign revoke    = 1'b0;
    assign pick_mask = '0;
`endif

    rr_pick8 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .mask   (pick_mask),
        .found  (found),
        .win_id (win_id)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (found)       state_d = BUSY;
            BUSY: if (release_now) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Grant and pointer registers. Winner comes from req sampled in IDLE;
    // other requests are ignored while BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
        end else begin
            if (state_q == IDLE) begin
                if (found) begin
                    gnt_q    <= id_to_onehot(win_id);
                    gnt_id_q <= win_id;
                    ptr_q    <= win_id + 3'd1;
                end
            end else if (release_now) begin
                gnt_q    <= '0;
                gnt_id_q <= '0;
            end
        end
    end

    // Outputs
    always_comb begin
        gnt       = gnt_q;
        gnt_id    = gnt_id_q;
        gnt_valid = |gnt_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_rr_arbiter8_enc.sv
// Testbench for rr_arbiter8_enc. Inputs change 1 time unit after the rising
// edge; outputs are checked at that same point, i.e. away from the edge.
module tb_rr_arbiter8_enc;
    import arb8_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    arb_state_e state_dbg;
`ifdef ARB_TIMEOUT_EN
    logic       timeout;
`endif

    int checks = 0;
    int errors = 0;

    rr_arbiter8_enc #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
`ifdef ARB_TIMEOUT_EN
        .timeout   (timeout),
`endif
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Driver-side expectation check of the grant outputs.
    task automatic test_reset();
        do_reset();
        checks++;
        if (gnt !== 8'h00 || gnt_id !== 3'd0 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%h id=%0d v=%b exp gnt=00 id=0 v=0", gnt, gnt_id, gnt_valid);
        end
        checks++;
        if (state_dbg !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d exp IDLE", state_dbg);
        end
`ifdef ARB_TIMEOUT_EN
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_timeout: got %b exp 0", timeout);
        end
`endif
    endtask

    // Single requester: 1-cycle latency, release at next edge, re-grant after bubble.
    task automatic test_single();
        do_reset();
        req = 8'h01;
        tick();
        checks++;
        if (gnt !== 8'h01 || gnt_id !== 3'd7 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: gnt=%h id=%0d v=%b exp gnt=01 id=7 v=1", gnt, gnt_id, gnt_valid);
        end
        req = 8'h00;
        tick();
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_id !== 3'd0) begin
            errors++;
            $display("FAIL single_release: gnt=%h id=%0d v=%b exp gnt=00 id=0 v=0", gnt, gnt_id, gnt_valid);
        end
        // Drop and re-raise back to back as the only requester.
        req = 8'h01;
        tick();
        checks++;
        if (gnt !== 8'h01 || gnt_id !== 3'd7) begin
            errors++;
            $display("FAIL single_regrant: gnt=%h id=%0d exp gnt=01 id=7", gnt, gnt_id);
        end
        req = 8'h00;
        tick();
        checks++;
        if (gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_bubble: v=%b exp 0", gnt_valid);
        end
        req = 8'h01;
        tick();
        checks++;
        if (gnt !== 8'h01 || gnt_id !== 3'd7) begin
            errors++;
            $display("FAIL single_regrant2: gnt=%h id=%0d exp gnt=01 id=7", gnt, gnt_id);
        end
        req = 8'h00;
        tick();
    endtask

    // All requesting; each owner drops for one cycle to release.
    task automatic test_all_rr();
        logic [7:0] exp_gnt;
        logic [2:0] exp_id;
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            exp_id  = 3'(i % 8);
            exp_gnt = 8'h80 >> exp_id;
            tick();
            checks++;
            if (gnt !== exp_gnt || gnt_id !== exp_id || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL all_rr_grant[%0d]: gnt=%h id=%0d v=%b exp gnt=%h id=%0d v=1",
                         i, gnt, gnt_id, gnt_valid, exp_gnt, exp_id);
            end
            req = 8'hFF & ~exp_gnt;
            tick();
            checks++;
            if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
                errors++;
                $display("FAIL all_rr_bubble[%0d]: gnt=%h v=%b exp gnt=00 v=0", i, gnt, gnt_valid);
            end
            req = 8'hFF;
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    // No preemption: ID 2 keeps the grant while ID 0 also asks.
    task automatic test_no_preempt();
        do_reset();
        req = 8'h20;
        tick();
        checks++;
        if (gnt !== 8'h20 || gnt_id !== 3'd2) begin
            errors++;
            $display("FAIL nopre_grant: gnt=%h id=%0d exp gnt=20 id=2", gnt, gnt_id);
        end
        req = 8'hA0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (gnt !== 8'h20 || gnt_id !== 3'd2) begin
                errors++;
                $display("FAIL nopre_hold[%0d]: gnt=%h id=%0d exp gnt=20 id=2", i, gnt, gnt_id);
            end
        end
        req = 8'h80;
        tick();
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL nopre_bubble: gnt=%h v=%b exp gnt=00 v=0", gnt, gnt_valid);
        end
        tick();
        checks++;
        if (gnt !== 8'h80 || gnt_id !== 3'd0) begin
            errors++;
            $display("FAIL nopre_next: gnt=%h id=%0d exp gnt=80 id=0", gnt, gnt_id);
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    // Reset while BUSY; then pointer restarts at ID 0.
    task automatic test_reset_busy();
        do_reset();
        req = 8'h10;
        tick();
        checks++;
        if (gnt !== 8'h10 || gnt_id !== 3'd3) begin
            errors++;
            $display("FAIL rstbusy_grant: gnt=%h id=%0d exp gnt=10 id=3", gnt, gnt_id);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (gnt !== 8'h00 || gnt_id !== 3'd0 || gnt_valid !== 1'b0 || state_dbg !== IDLE) begin
            errors++;
            $display("FAIL rstbusy_clear: gnt=%h id=%0d v=%b st=%0d exp gnt=00 id=0 v=0 st=IDLE",
                     gnt, gnt_id, gnt_valid, state_dbg);
        end
        // With pointer at 0, ID 3 beats ID 7; a stale pointer of 4 would pick ID 7.
        rst = 1'b0;
        req = 8'h11;
        tick();
        checks++;
        if (gnt !== 8'h10 || gnt_id !== 3'd3) begin
            errors++;
            $display("FAIL rstbusy_ptr: gnt=%h id=%0d exp gnt=10 id=3", gnt, gnt_id);
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    // Winner decided from IDLE sample; owner dropping in first BUSY cycle ends grant.
    task automatic test_change_at_load();
        do_reset();
        req = 8'h04;
        tick();
        checks++;
        if (gnt !== 8'h04 || gnt_id !== 3'd5) begin
            errors++;
            $display("FAIL load_grant: gnt=%h id=%0d exp gnt=04 id=5", gnt, gnt_id);
        end
        req = 8'h02;
        tick();
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_drop: gnt=%h v=%b exp gnt=00 v=0", gnt, gnt_valid);
        end
        tick();
        checks++;
        if (gnt !== 8'h02 || gnt_id !== 3'd6) begin
            errors++;
            $display("FAIL load_next: gnt=%h id=%0d exp gnt=02 id=6", gnt, gnt_id);
        end
        req = 8'h00;
        tick();
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    // TIMEOUT_CYCLES=4 with req[7] and req[0] held.
    task automatic test_timeout();
        do_reset();
        req = 8'h81;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (gnt !== 8'h80 || gnt_id !== 3'd0 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold0[%0d]: gnt=%h id=%0d to=%b exp gnt=80 id=0 to=0", i, gnt, gnt_id, timeout);
            end
        end
        tick();
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_revoke0: gnt=%h to=%b exp gnt=00 to=1", gnt, timeout);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (gnt !== 8'h01 || gnt_id !== 3'd7 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold7[%0d]: gnt=%h id=%0d to=%b exp gnt=01 id=7 to=0", i, gnt, gnt_id, timeout);
            end
        end
        tick();
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_revoke7: gnt=%h to=%b exp gnt=00 to=1", gnt, timeout);
        end
        // Both masked now: no grant while req stays 8'h81.
        tick();
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_blocked: gnt=%h to=%b exp gnt=00 to=0", gnt, timeout);
        end
        req = 8'h01;
        tick();
        checks++;
        if (gnt !== 8'h00) begin
            errors++;
            $display("FAIL to_blocked7: gnt=%h exp 00", gnt);
        end
        req = 8'h81;
        tick();
        checks++;
        if (gnt !== 8'h80 || gnt_id !== 3'd0) begin
            errors++;
            $display("FAIL to_regrant0: gnt=%h id=%0d exp gnt=80 id=0", gnt, gnt_id);
        end
        req = 8'h00;
        tick();
        tick();
    endtask
`else
    // Random requests, checked against properties of the protocol.
    task automatic test_random();
        logic [7:0] req_prev;
        logic [7:0] gnt_prev;
        logic [2:0] id_calc;
        int         ones;
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
            req_prev = req;
            gnt_prev = gnt;
            tick();
            ones    = 0;
            id_calc = 3'd0;
            for (int i = 0; i < 8; i++) begin
                if (gnt[i]) begin
                    ones++;
                    id_calc = 3'(7 - i);
                end
            end
            checks++;
            if (ones > 1) begin
                errors++;
                $display("FAIL rnd_onehot[%0d]: gnt=%h exp zero or one-hot", n, gnt);
            end
            checks++;
            if (gnt_id !== id_calc || gnt_valid !== (ones != 0)) begin
                errors++;
                $display("FAIL rnd_id[%0d]: id=%0d v=%b exp id=%0d v=%b", n, gnt_id, gnt_valid, id_calc, ones != 0);
            end
            checks++;
            if (gnt_prev != 8'h00) begin
                if ((req_prev & gnt_prev) != 8'h00 && gnt !== gnt_prev) begin
                    errors++;
                    $display("FAIL rnd_hold[%0d]: gnt=%h exp %h", n, gnt, gnt_prev);
                end else if ((req_prev & gnt_prev) == 8'h00 && gnt !== 8'h00) begin
                    errors++;
                    $display("FAIL rnd_release[%0d]: gnt=%h exp 00", n, gnt);
                end
            end else if (req_prev != 8'h00 && (gnt & req_prev) == 8'h00) begin
                errors++;
                $display("FAIL rnd_idle_grant[%0d]: gnt=%h req=%h exp a requesting bit", n, gnt, req_prev);
            end
        end
        req = 8'h00;
        tick();
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        req = 8'h00;
        test_reset();
        test_single();
        test_all_rr();
        test_no_preempt();
        test_reset_busy();
        test_change_at_load();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_random();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
